// File: rtl/rv32im_sim_pkg.sv
// rv32im_sim_pkg: shared types, constants and helpers for the sim run/dump controller
package rv32im_sim_pkg;

    typedef enum logic [2:0] {RESET_HOLD, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE} state_e;
    typedef enum logic [1:0] {RUNNING, PASS, FAIL, TIMEOUT} status_e;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Counter width able to hold 0..n, never narrower than one bit
    function automatic int cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/rv32im_sig_crc32.sv
// rv32im_sig_crc32: reflected CRC-32 over 32-bit words, LSB byte first, one word per cycle
module rv32im_sig_crc32
    import rv32im_sim_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_R = bit_rev32(CRC32_POLY);

    logic [31:0] crc_q, crc_d;

    // Fold all 32 data bits LSB first, which equals feeding the bytes LSB byte first
    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 32; i++) crc_d = (crc_d >> 1) ^ ((crc_d[0] ^ data_i[i]) ? POLY_R : 32'h0);
    end

    // Running CRC register, preset to all ones so the output reads 0 in reset
    always_ff @(posedge clk_i) begin
        if (reset_i) crc_q <= '1;
        else if (en_i) crc_q <= crc_d;
    end

    assign crc_o = ~crc_q;

endmodule

// File: rtl/rv32im_sim_ctrl.sv
// rv32im_sim_ctrl: holds the core in reset, runs it until tohost or timeout, drains, then streams a DMEM signature dump (SIGNATURE_CRC_EN adds sig_crc_o)
module rv32im_sim_ctrl
    import rv32im_sim_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 10,
    parameter int unsigned TIMEOUT_CYCLES = 40000,
    parameter int unsigned DRAIN_CYCLES   = 8,
    parameter int unsigned DUMP_WORDS     = 128,
    parameter logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_01FC,
    localparam int IW = cnt_w(DUMP_WORDS)
)(
    input  logic          clk_i,
    input  logic          reset_i,
    output logic          cpu_reset_o,
    input  logic          snp_we_i,
    input  logic [31:0]   snp_addr_i,
    input  logic [31:0]   snp_wdata_i,
    output logic          dump_rd_en_o,
    output logic [31:0]   dump_addr_o,
    input  logic [31:0]   dump_rdata_i,
    output logic          dump_valid_o,
    input  logic          dump_ready_i,
    output logic [31:0]   dump_data_o,
    output logic [IW-1:0] dump_index_o,
    output logic          done_o,
    output logic [1:0]    status_o,
    output logic [30:0]   fail_code_o
`ifdef SIGNATURE_CRC_EN
    ,
    output logic [31:0]   sig_crc_o
`endif
);

    localparam int HW = cnt_w(RESET_CYCLES);
    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam int DW = cnt_w(DRAIN_CYCLES);

    if (64'(DMEM_BASE_ADDR) + 64'(DUMP_WORDS) * 64'd4 > 64'h1_0000_0000) begin : g_addr_overflow
        $error("dump address range runs past 2^32");
    end

    state_e        state_q, state_d;
    status_e       status_q, status_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] run_q, run_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [30:0]   fail_q, fail_d;
    logic [31:0]   data_q, data_d;
    logic          cap_q, cap_d;
    logic          hit;

    assign hit = snp_we_i && snp_addr_i == TOHOST_ADDR && snp_wdata_i[0];

    // Next-state and counter logic for the run/drain/dump sequence
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        hold_d   = hold_q;
        run_d    = run_q;
        drain_d  = drain_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        data_d   = data_q;
        cap_d    = cap_q;
        case (state_q)
            RESET_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (32'(hold_q) == RESET_CYCLES - 1) state_d = RUN;
            end
            RUN: begin
                run_d = run_q + 1'b1;
                if (hit) begin
                    status_d = (snp_wdata_i == 32'd1) ? PASS : FAIL;
                    fail_d   = snp_wdata_i[31:1];
                    state_d  = DRAIN;
                end else if (32'(run_q) == TIMEOUT_CYCLES - 1) begin
                    status_d = TIMEOUT;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (32'(drain_q) == DRAIN_CYCLES - 1) state_d = (DUMP_WORDS == 0) ? DONE : DUMP_RD;
            end
            DUMP_RD: begin
                cap_d   = 1'b0;
                state_d = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (!cap_q) begin
                    data_d = dump_rdata_i;
                    cap_d  = 1'b1;
                end
                if (dump_ready_i) begin
                    cap_d = 1'b0;
                    if (32'(idx_q) == DUMP_WORDS - 1) state_d = DONE;
                    else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = DUMP_RD;
                    end
                end
            end
            DONE: state_d = DONE;
            default: state_d = RESET_HOLD;
        endcase
    end

    // State and datapath registers; reset discards any run or partial dump
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= RESET_HOLD;
            status_q <= RUNNING;
            hold_q   <= '0;
            run_q    <= '0;
            drain_q  <= '0;
            idx_q    <= '0;
            fail_q   <= '0;
            data_q   <= '0;
            cap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            hold_q   <= hold_d;
            run_q    <= run_d;
            drain_q  <= drain_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            data_q   <= data_d;
            cap_q    <= cap_d;
        end
    end

    // The first DUMP_OUT cycle forwards the read data directly so a word needs only two cycles
    assign cpu_reset_o  = state_q == RESET_HOLD;
    assign dump_rd_en_o = state_q == DUMP_RD;
    assign dump_addr_o  = DMEM_BASE_ADDR + 32'({idx_q, 2'b00});
    assign dump_valid_o = state_q == DUMP_OUT;
    assign dump_data_o  = (dump_valid_o && !cap_q) ? dump_rdata_i : data_q;
    assign dump_index_o = idx_q;
    assign done_o       = state_q == DONE;
    assign status_o     = status_q;
    assign fail_code_o  = fail_q;

`ifdef SIGNATURE_CRC_EN
    rv32im_sig_crc32 u_crc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (dump_valid_o && dump_ready_i),
        .data_i  (dump_data_o),
        .crc_o   (sig_crc_o)
    );
`endif

endmodule

// File: tb/tb_rv32im_sim_ctrl.sv
// tb_rv32im_sim_ctrl: scoreboard bench for the run/dump controller (4-word and 0-word dump instances)
module tb_rv32im_sim_ctrl;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] TOHOST = 32'h8000_01FC;

    logic        clk = 1'b0, reset = 1'b1;
    logic        snp_we = 1'b0;
    logic [31:0] snp_addr = '0, snp_wdata = '0;

    logic        a_cpu_reset, a_rd_en, a_valid, a_done;
    logic        a_ready = 1'b0;
    logic [31:0] a_addr, a_data;
    logic [31:0] a_rdata = '0;
    logic [2:0]  a_index;
    logic [1:0]  a_status;
    logic [30:0] a_fail;

    logic        b_cpu_reset, b_rd_en, b_valid, b_done;
    logic [31:0] b_addr, b_data;
    logic [0:0]  b_index;
    logic [1:0]  b_status;
    logic [30:0] b_fail;
`ifdef SIGNATURE_CRC_EN
    logic [31:0] a_crc, b_crc;
`endif

    int          n_tests = 0, n_fail = 0;
    logic        rand_ready = 1'b0;
    logic        b_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [2:0]  prev_index = '0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    rv32im_sim_ctrl #(
        .RESET_CYCLES(10), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(8), .DUMP_WORDS(4),
        .DMEM_BASE_ADDR(BASE), .TOHOST_ADDR(TOHOST)
    ) u_dut (
        .clk_i(clk), .reset_i(reset), .cpu_reset_o(a_cpu_reset),
        .snp_we_i(snp_we), .snp_addr_i(snp_addr), .snp_wdata_i(snp_wdata),
        .dump_rd_en_o(a_rd_en), .dump_addr_o(a_addr), .dump_rdata_i(a_rdata),
        .dump_valid_o(a_valid), .dump_ready_i(a_ready), .dump_data_o(a_data),
        .dump_index_o(a_index), .done_o(a_done), .status_o(a_status), .fail_code_o(a_fail)
`ifdef SIGNATURE_CRC_EN
        , .sig_crc_o(a_crc)
`endif
    );

    rv32im_sim_ctrl #(
        .RESET_CYCLES(10), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(8), .DUMP_WORDS(0),
        .DMEM_BASE_ADDR(BASE), .TOHOST_ADDR(TOHOST)
    ) u_dut0 (
        .clk_i(clk), .reset_i(reset), .cpu_reset_o(b_cpu_reset),
        .snp_we_i(snp_we), .snp_addr_i(snp_addr), .snp_wdata_i(snp_wdata),
        .dump_rd_en_o(b_rd_en), .dump_addr_o(b_addr), .dump_rdata_i(32'h0),
        .dump_valid_o(b_valid), .dump_ready_i(1'b1), .dump_data_o(b_data),
        .dump_index_o(b_index), .done_o(b_done), .status_o(b_status), .fail_code_o(b_fail)
`ifdef SIGNATURE_CRC_EN
        , .sig_crc_o(b_crc)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_words();
        for (int i = 0; i < 4; i++) exp_q.push_back({3'(i), 32'hA5A5_0000 + 32'(i)});
    endtask

    task automatic tohost_write(input logic [31:0] addr, input logic [31:0] wdata);
        snp_we = 1'b1;
        snp_addr = addr;
        snp_wdata = wdata;
        step();
        snp_we = 1'b0;
    endtask

    task automatic wait_run();
        int k = 0;
        while (a_cpu_reset && k < 100) begin
            step();
            k++;
        end
        chk("run_start", a_cpu_reset, 0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!a_done && k < 1000) begin
            step();
            k++;
        end
        chk("done_reached", a_done, 1);
        chk("sb_drained", exp_q.size(), 0);
    endtask

`ifdef SIGNATURE_CRC_EN
    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c, d;
        c = '1;
        for (int w = 0; w < n; w++) begin
            d = 32'hA5A5_0000 + 32'(w);
            for (int b = 0; b < 4; b++) begin
                c ^= {24'h0, d[8*b +: 8]};
                for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction
`endif

    // DMEM model: registered read port, junk when not enabled
    always @(posedge clk) a_rdata <= a_rd_en ? 32'hA5A5_0000 + ((a_addr - BASE) >> 2) : $urandom;

    // Stream sink ready, random when backpressure is enabled
    always @(posedge clk) begin
        #1;
        a_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Scoreboard monitor: pops on each accepted word, checks holds under stall
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && a_valid) begin
                chk("hold_data", a_data, prev_data);
                chk("hold_index", a_index, prev_index);
            end
            if (a_valid && a_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    chk("word_data", a_data, e[31:0]);
                    chk("word_index", a_index, e[34:32]);
                end
            end
            if (b_valid) b_seen = 1'b1;
            prev_stall = a_valid && !a_ready;
            prev_data = a_data;
            prev_index = a_index;
        end else prev_stall = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(2);
        chk("rst_cpu_reset", a_cpu_reset, 1);
        chk("rst_valid", a_valid, 0);
        chk("rst_done", a_done, 0);
        chk("rst_status", a_status, 0);
        chk("rst_index", a_index, 0);
        chk("rst_rd_en", a_rd_en, 0);
        chk("rst_fail", a_fail, 0);
        chk("rst_b_cpu_reset", b_cpu_reset, 1);
`ifdef SIGNATURE_CRC_EN
        chk("rst_crc", a_crc, 0);
`endif
        // Pass path with ready tied high
        push_words();
        reset = 1'b0;
        step(9);
        chk("hold_last", a_cpu_reset, 1);
        step();
        chk("run_entry", a_cpu_reset, 0);
        step(50);
        chk("running", a_status, 0);
        tohost_write(TOHOST, 32'd1);
        chk("pass_status", a_status, 1);
        chk("pass_b_status", b_status, 1);
        step(7);
        chk("b_done_early", b_done, 0);
        step();
        chk("b_done", b_done, 1);
        step(7);
        chk("a_done_early", a_done, 0);
        step();
        chk("a_done", a_done, 1);
        chk("pass_sb", exp_q.size(), 0);
`ifdef SIGNATURE_CRC_EN
        chk("pass_crc", a_crc, crc_model(4));
        chk("b_crc", b_crc, 0);
`endif
        // Fail path with ignored writes and random backpressure
        reset = 1'b1;
        step();
        reset = 1'b0;
        rand_ready = 1'b1;
        push_words();
        wait_run();
        step(5);
        tohost_write(TOHOST, 32'd6);
        chk("even_ignored", a_status, 0);
        tohost_write(TOHOST + 32'd4, 32'd1);
        chk("other_addr_ignored", a_status, 0);
        step(3);
        tohost_write(TOHOST, 32'd7);
        chk("fail_status", a_status, 2);
        chk("fail_code", a_fail, 3);
        wait_done();
        chk("fail_status_held", a_status, 2);
        chk("fail_code_held", a_fail, 3);
        // Mid-dump reset at word 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_words();
        wait_run();
        begin
            int k = 0;
            while (!(a_valid && a_index == 3'd2) && k < 500) begin
                step();
                k++;
            end
        end
        chk("reach_word2", {a_valid, a_index}, {1'b1, 3'd2});
        reset = 1'b1;
        step();
        chk("mid_cpu_reset", a_cpu_reset, 1);
        chk("mid_valid", a_valid, 0);
        chk("mid_done", a_done, 0);
        chk("mid_index", a_index, 0);
        chk("mid_status", a_status, 0);
        chk("mid_consumed", exp_q.size(), 2);
        exp_q.delete();
        // Clean repeat: timeout after exactly 100 RUN cycles, dump still occurs
        push_words();
        reset = 1'b0;
        step(9);
        chk("rep_hold_last", a_cpu_reset, 1);
        step();
        chk("rep_run_entry", a_cpu_reset, 0);
        step(99);
        chk("timeout_early", a_status, 0);
        step();
        chk("timeout_status", a_status, 3);
        chk("timeout_b_status", b_status, 3);
        wait_done();
        chk("timeout_held", a_status, 3);
        chk("b_done_final", b_done, 1);
        chk("b_never_valid", b_seen, 0);
`ifdef SIGNATURE_CRC_EN
        chk("timeout_crc", a_crc, crc_model(4));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
